// File: rtl/serial_bus_pkg.sv
// Shared types and instruction codes for the serial bus slave path.
package serial_bus_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    WDATA   = 3'd2,
    WCOMMIT = 3'd3,
    RREQ    = 3'd4,
    DONE    = 3'd5
  } slave_in_state_t;

  localparam logic [2:0] S_READ    = 3'd1;
  localparam logic [2:0] S_WRITE   = 3'd2;
  localparam logic [2:0] S_B_READ  = 3'd3;
  localparam logic [2:0] S_B_WRITE = 3'd4;

  function automatic logic is_read_code(input logic [2:0] code);
    return (code == S_READ) || (code == S_B_READ);
  endfunction

  function automatic logic is_write_code(input logic [2:0] code);
    return (code == S_WRITE) || (code == S_B_WRITE);
  endfunction

endpackage

// File: rtl/serial_deser.sv
// LSB-first serial-to-parallel collector; 'data' already includes the bit shifted this cycle.
// Counter wraps to 0 after the last bit, so back-to-back words need no explicit clear.
module serial_deser #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             bit_in,
  input  logic             clr,
  output logic [WIDTH-1:0] data,
  output logic             last
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] data_q;

  assign last = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    data = data_q;
    if (en) data[cnt] = bit_in;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt    <= '0;
      data_q <= '0;
    end else if (en) begin
      data_q <= data;
      cnt    <= last ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/slave_in_port.sv
// Slave receive port: deserializes address/write data, issues valid/ack requests to the core.
// Write request one cycle after the last data bit; s_ready is registered and drops during commit/read/done.
module slave_in_port
  import serial_bus_pkg::*;
#(
  parameter int SLAVE_ADDR_SIZE = 12,
  parameter int WORD_SIZE       = 8,
  parameter int BURST_W         = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sel,
  input  logic                       addr_bus,
  input  logic                       addr_valid,
  input  logic                       w_data_bus,
  input  logic                       m_valid,
  input  logic                       read_en,
  input  logic                       write_en,
  input  logic [BURST_W-1:0]         burst_size,
  output logic                       s_ready,
  output logic                       wr_valid,
  output logic [SLAVE_ADDR_SIZE-1:0] wr_addr,
  output logic [WORD_SIZE-1:0]       wr_data,
  input  logic                       wr_ack,
  output logic                       rd_valid,
  output logic [SLAVE_ADDR_SIZE-1:0] rd_addr,
  input  logic                       rd_ack,
  output logic                       rx_done,
  output logic                       rx_abort
);

  slave_in_state_t state_q, state_nxt;

  logic                       ready_q;
  logic                       abort_nxt, abort_q;
  logic [SLAVE_ADDR_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0]       wdata_q;
  logic [BURST_W-1:0]         burst_q, word_cnt;

  logic                       addr_en, addr_last, addr_done;
  logic                       data_en, data_last, data_done;
  logic [SLAVE_ADDR_SIZE-1:0] addr_word;
  logic [WORD_SIZE-1:0]       data_word;
  logic                       last_word, step, clr_cnt, in_xfer;

  assign s_ready   = ready_q;
  assign addr_en   = ready_q && sel && addr_valid && (state_q == IDLE || state_q == ADDR);
  assign addr_done = addr_en && addr_last;
  assign data_en   = ready_q && sel && m_valid && (state_q == WDATA);
  assign data_done = data_en && data_last;
  assign last_word = (word_cnt == burst_q - BURST_W'(1));
  assign in_xfer   = (state_q == ADDR) || (state_q == WDATA) ||
                     (state_q == WCOMMIT) || (state_q == RREQ);
  assign step      = sel && !last_word &&
                     ((state_q == WCOMMIT && wr_ack) || (state_q == RREQ && rd_ack));
  assign clr_cnt   = (state_nxt == IDLE);

  serial_deser #(.WIDTH(SLAVE_ADDR_SIZE)) u_addr_deser (
    .clk    (clk),
    .rst    (rst),
    .en     (addr_en),
    .bit_in (addr_bus),
    .clr    (clr_cnt),
    .data   (addr_word),
    .last   (addr_last)
  );

  serial_deser #(.WIDTH(WORD_SIZE)) u_data_deser (
    .clk    (clk),
    .rst    (rst),
    .en     (data_en),
    .bit_in (w_data_bus),
    .clr    (clr_cnt),
    .data   (data_word),
    .last   (data_last)
  );

  always_comb begin
    state_nxt = state_q;
    abort_nxt = 1'b0;
    case (state_q)
      IDLE:    if (sel && ready_q) state_nxt = ADDR;
      ADDR:    ;
      WDATA:   if (data_done) state_nxt = WCOMMIT;
      WCOMMIT: if (wr_ack) state_nxt = last_word ? DONE : WDATA;
      RREQ:    if (rd_ack) state_nxt = last_word ? DONE : RREQ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Address decode also covers bit 0 landing in IDLE (single-bit address widths).
    if (addr_done) begin
      if (write_en && !read_en)      state_nxt = WDATA;
      else if (read_en && !write_en) state_nxt = RREQ;
      else begin
        state_nxt = IDLE;
        abort_nxt = 1'b1;
      end
    end
    // Losing select wins over everything, including an ack in the same cycle.
    if (!sel && in_xfer) begin
      state_nxt = IDLE;
      abort_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      abort_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      burst_q  <= '0;
      word_cnt <= '0;
    end else begin
      state_q <= state_nxt;
      ready_q <= (state_nxt == IDLE) || (state_nxt == ADDR) || (state_nxt == WDATA);
      abort_q <= abort_nxt;
      if (addr_done) begin
        addr_q  <= addr_word;
        burst_q <= (burst_size == '0) ? BURST_W'(1) : burst_size;
      end
      if (data_done) wdata_q <= data_word;
      if (clr_cnt || addr_done) begin
        word_cnt <= '0;
      end else if (step) begin
        word_cnt <= word_cnt + BURST_W'(1);
        addr_q   <= addr_q + SLAVE_ADDR_SIZE'(1);
      end
    end
  end

  assign wr_valid = (state_q == WCOMMIT) && sel;
  assign rd_valid = (state_q == RREQ) && sel;
  assign wr_addr  = addr_q;
  assign rd_addr  = addr_q;
  assign wr_data  = wdata_q;
  assign rx_done  = (state_q == DONE);
  assign rx_abort = abort_q;

endmodule

// File: tb/tb_slave_in_port.sv
// Directed bench for slave_in_port: single/burst write, burst read, abort, reset, decode errors.
module tb_slave_in_port;
  import serial_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst, sel, addr_bus, addr_valid, w_data_bus, m_valid;
  logic        read_en, write_en, wr_ack, rd_ack;
  logic [3:0]  burst_size;
  logic        s_ready, wr_valid, rd_valid, rx_done, rx_abort;
  logic [11:0] wr_addr, rd_addr;
  logic [7:0]  wr_data;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;

  slave_in_port dut (
    .clk        (clk),
    .rst        (rst),
    .sel        (sel),
    .addr_bus   (addr_bus),
    .addr_valid (addr_valid),
    .w_data_bus (w_data_bus),
    .m_valid    (m_valid),
    .read_en    (read_en),
    .write_en   (write_en),
    .burst_size (burst_size),
    .s_ready    (s_ready),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .rd_valid   (rd_valid),
    .rd_addr    (rd_addr),
    .rd_ack     (rd_ack),
    .rx_done    (rx_done),
    .rx_abort   (rx_abort)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_valid && wr_ack) wr_cnt++;
    if (rd_valid && rd_ack) rd_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_addr(input logic [11:0] a, input logic rd, input logic wr,
                           input logic [3:0] b);
    sel = 1'b1;
    for (int i = 0; i < 12; i++) begin
      addr_valid = 1'b1;
      addr_bus   = a[i];
      if (i == 11) begin
        read_en    = rd;
        write_en   = wr;
        burst_size = b;
      end
      tick();
    end
    addr_valid = 1'b0;
    read_en    = 1'b0;
    write_en   = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      m_valid    = 1'b1;
      w_data_bus = d[i];
      tick();
    end
    m_valid = 1'b0;
  endtask

  logic [11:0] bw_addr [3];
  logic [7:0]  bw_data [3];

  initial begin
    bw_addr[0] = 12'hFFF; bw_addr[1] = 12'h000; bw_addr[2] = 12'h001;
    bw_data[0] = 8'h11;   bw_data[1] = 8'h22;   bw_data[2] = 8'h33;

    rst = 1'b1; sel = 1'b0; addr_bus = 1'b0; addr_valid = 1'b0;
    w_data_bus = 1'b0; m_valid = 1'b0; read_en = 1'b0; write_en = 1'b0;
    burst_size = 4'd0; wr_ack = 1'b0; rd_ack = 1'b0;
    tick();
    tick();
    chk("rst_s_ready",  32'(s_ready),  32'h0);
    chk("rst_wr_valid", 32'(wr_valid), 32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_rx_done",  32'(rx_done),  32'h0);
    chk("rst_rx_abort", 32'(rx_abort), 32'h0);
    chk("rst_wr_addr",  32'(wr_addr),  32'h0);
    chk("rst_wr_data",  32'(wr_data),  32'h0);
    chk("rst_rd_addr",  32'(rd_addr),  32'h0);
    rst = 1'b0;
    tick();
    chk("idle_s_ready", 32'(s_ready), 32'h1);

    // Single write
    send_addr(12'h0A5, is_read_code(S_WRITE), is_write_code(S_WRITE), 4'd1);
    chk("w1_wdata_ready", 32'(s_ready),  32'h1);
    chk("w1_no_valid",    32'(wr_valid), 32'h0);
    send_bits(8'h3C, 8);
    chk("w1_valid",  32'(wr_valid), 32'h1);
    chk("w1_addr",   32'(wr_addr),  32'h0A5);
    chk("w1_data",   32'(wr_data),  32'h3C);
    chk("w1_ready0", 32'(s_ready),  32'h0);
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    chk("w1_done",       32'(rx_done),  32'h1);
    chk("w1_valid_gone", 32'(wr_valid), 32'h0);
    sel = 1'b0;
    tick();
    chk("w1_done_pulse", 32'(rx_done), 32'h0);
    chk("w1_wr_cnt",     32'(wr_cnt),  32'd1);

    // Burst write of 3 with wrapping address, ack after 2 stall cycles
    send_addr(12'hFFF, is_read_code(S_B_WRITE), is_write_code(S_B_WRITE), 4'd3);
    for (int k = 0; k < 3; k++) begin
      send_bits(bw_data[k], 8);
      chk("bw_valid", 32'(wr_valid), 32'h1);
      chk("bw_addr",  32'(wr_addr),  32'(bw_addr[k]));
      chk("bw_data",  32'(wr_data),  32'(bw_data[k]));
      chk("bw_ready", 32'(s_ready),  32'h0);
      tick();
      tick();
      chk("bw_hold_valid", 32'(wr_valid), 32'h1);
      chk("bw_hold_addr",  32'(wr_addr),  32'(bw_addr[k]));
      chk("bw_hold_ready", 32'(s_ready),  32'h0);
      wr_ack = 1'b1;
      tick();
      wr_ack = 1'b0;
      if (k < 2) begin
        chk("bw_ready_back", 32'(s_ready),  32'h1);
        chk("bw_valid_low",  32'(wr_valid), 32'h0);
      end else begin
        chk("bw_done", 32'(rx_done), 32'h1);
      end
    end
    sel = 1'b0;
    tick();
    chk("bw_wr_cnt", 32'(wr_cnt), 32'd4);

    // Burst read of 4, ack tied high
    rd_ack = 1'b1;
    send_addr(12'h010, is_read_code(S_B_READ), is_write_code(S_B_READ), 4'd4);
    for (int k = 0; k < 4; k++) begin
      chk("br_valid", 32'(rd_valid), 32'h1);
      chk("br_addr",  32'(rd_addr),  32'h010 + 32'(k));
      chk("br_ready", 32'(s_ready),  32'h0);
      tick();
    end
    chk("br_done",     32'(rx_done),  32'h1);
    chk("br_valid_lo", 32'(rd_valid), 32'h0);
    rd_ack = 1'b0;
    sel = 1'b0;
    tick();
    chk("br_rd_cnt", 32'(rd_cnt), 32'd4);

    // Abort after 5 of 8 data bits
    send_addr(12'h123, is_read_code(S_WRITE), is_write_code(S_WRITE), 4'd1);
    send_bits(8'hFF, 5);
    sel = 1'b0;
    tick();
    chk("ab_abort", 32'(rx_abort), 32'h1);
    chk("ab_valid", 32'(wr_valid), 32'h0);
    chk("ab_ready", 32'(s_ready),  32'h1);
    tick();
    chk("ab_pulse",  32'(rx_abort), 32'h0);
    chk("ab_wr_cnt", 32'(wr_cnt),   32'd4);
    send_addr(12'h456, is_read_code(S_WRITE), is_write_code(S_WRITE), 4'd1);
    send_bits(8'hA7, 8);
    chk("ab_next_addr", 32'(wr_addr), 32'h456);
    chk("ab_next_data", 32'(wr_data), 32'hA7);
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    chk("ab_next_done", 32'(rx_done), 32'h1);
    sel = 1'b0;
    tick();

    // Reset while a write is pending
    send_addr(12'h200, is_read_code(S_WRITE), is_write_code(S_WRITE), 4'd1);
    send_bits(8'h5A, 8);
    chk("rs_valid", 32'(wr_valid), 32'h1);
    rst = 1'b1;
    tick();
    chk("rs_wr_valid", 32'(wr_valid), 32'h0);
    chk("rs_wr_addr",  32'(wr_addr),  32'h0);
    chk("rs_wr_data",  32'(wr_data),  32'h0);
    chk("rs_rd_addr",  32'(rd_addr),  32'h0);
    chk("rs_s_ready",  32'(s_ready),  32'h0);
    chk("rs_rx_done",  32'(rx_done),  32'h0);
    chk("rs_rx_abort", 32'(rx_abort), 32'h0);
    rst = 1'b0;
    sel = 1'b0;
    tick();
    chk("rs_wr_cnt", 32'(wr_cnt), 32'd5);

    // burst_size 0 acts as a single word, ack in the same cycle as valid
    send_addr(12'h321, is_read_code(S_WRITE), is_write_code(S_WRITE), 4'd0);
    send_bits(8'h99, 8);
    chk("b0_addr", 32'(wr_addr), 32'h321);
    chk("b0_data", 32'(wr_data), 32'h99);
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    chk("b0_done",  32'(rx_done),  32'h1);
    chk("b0_valid", 32'(wr_valid), 32'h0);
    sel = 1'b0;
    tick();
    chk("b0_wr_cnt", 32'(wr_cnt), 32'd6);

    // Both read_en and write_en on the last address bit
    send_addr(12'h0F0, 1'b1, 1'b1, 4'd1);
    chk("both_abort",    32'(rx_abort), 32'h1);
    chk("both_wr_valid", 32'(wr_valid), 32'h0);
    chk("both_rd_valid", 32'(rd_valid), 32'h0);
    sel = 1'b0;
    tick();
    chk("both_pulse", 32'(rx_abort), 32'h0);
    chk("both_cnt",   32'(wr_cnt + rd_cnt), 32'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/slave_in_port.md
# slave_in_port

Slave-side receive port of the serial bus. It sits directly downstream of the master output port on each slave. It deserializes the LSB-first address and write-data bit streams into parallel words, then hands them to the slave memory core with a valid/ack handshake. Bursts are supported with an auto-incrementing address, and `s_ready` provides per-bit flow control back to the master.

## Interface
- `SLAVE_ADDR_SIZE`, 12, address width and number of serial address bits per transaction
- `WORD_SIZE`, 8, data word width and number of serial data bits per word
- `BURST_W`, 4, width of the burst-length input

- `clk` in 1, single clock, all logic on rising edge
- `rst` in 1, synchronous, active-high reset
- `sel` in 1, this slave's `slave_select` bit; must stay high for the whole transaction
- `addr_bus` in 1, serial address bit, sampled when `addr_valid`
- `addr_valid` in 1, address bit qualifier
- `w_data_bus` in 1, serial write-data bit, sampled when `m_valid && s_ready`
- `m_valid` in 1, write-data bit qualifier
- `read_en` in 1, read transaction, sampled on the last address bit
- `write_en` in 1, write transaction, sampled on the last address bit
- `burst_size` in `BURST_W`, words in the transaction, sampled on the last address bit; 0 is treated as 1
- `s_ready` out 1, port can accept a bit this cycle
- `wr_valid` out 1, write request to the core
- `wr_addr` out `SLAVE_ADDR_SIZE`, write address
- `wr_data` out `WORD_SIZE`, write data
- `wr_ack` in 1, core accepted the write
- `rd_valid` out 1, read request to the core
- `rd_addr` out `SLAVE_ADDR_SIZE`, read address
- `rd_ack` in 1, core accepted the read
- `rx_done` out 1, one-cycle pulse when the transaction is complete
- `rx_abort` out 1, one-cycle pulse when `sel` drops mid-transaction

## Operation
- FSM states: `IDLE`, `ADDR`, `WDATA`, `WCOMMIT`, `RREQ`, `DONE`.
- `IDLE`
  - `sel`=1 → `ADDR`.
  - `addr_valid` in the same cycle is already captured as bit 0.
- `ADDR`
  - On each `addr_valid`, shift `addr_bus` into bit position `addr_cnt`, then increment `addr_cnt`.
  - On bit `SLAVE_ADDR_SIZE-1`, latch `burst_size`, then decode:
    - `write_en` → `WDATA`.
    - `read_en` → `RREQ`.
    - neither, or both → `IDLE` with `rx_abort`.
- `WDATA`
  - On each `m_valid && s_ready`, shift `w_data_bus` into bit `data_cnt`.
  - On bit `WORD_SIZE-1` → `WCOMMIT`.
- `WCOMMIT`
  - `wr_valid`=1, with `wr_addr`/`wr_data` held stable until `wr_ack`.
  - On `wr_ack`, if `word_cnt==burst-1` → `DONE`.
  - Otherwise increment `word_cnt`, increment the address, and return to `WDATA`.
- `RREQ`
  - `rd_valid`=1 until `rd_ack`.
  - Same word/address stepping as `WCOMMIT`; last word → `DONE`.
- `DONE`
  - `rx_done`=1 for one cycle, then → `IDLE`.
- Address increments modulo 2^`SLAVE_ADDR_SIZE`, so all-ones wraps to 0.
- `s_ready` is 1 in `IDLE`, `ADDR` and `WDATA`, and 0 in `WCOMMIT`, `RREQ` and `DONE`.
- Abort: `sel`=0 in any state other than `IDLE`/`DONE`:
  - → `IDLE` next cycle, with a one-cycle `rx_abort`.
  - A partial word is discarded and never reaches the core.
  - A pending `wr_valid`/`rd_valid` is dropped, even if the ack arrives in the same cycle.
- Counters `addr_cnt`, `data_cnt` and `word_cnt` clear on entry to `IDLE`.

## Timing
- Reset values:
  - `s_ready`=0 while `rst` is high.
  - `wr_valid`, `rd_valid`, `rx_done`, `rx_abort` = 0.
  - `wr_addr`, `wr_data`, `rd_addr` = 0.
  - State = `IDLE`.
- Reset takes effect mid-transaction without any request to the core.
- Address: the last bit is sampled in cycle N; `wr_valid`/`rd_valid` paths start at N+1 (`WDATA` entered, or `rd_valid`=1).
- Write word: the last data bit is in cycle M; `wr_valid`=1 at M+1.
- An ack in the same cycle as the valid is legal; `s_ready` returns at M+2.
- Minimum write cost is `WORD_SIZE`+1 cycles per word.
- Read: minimum 1 cycle per word.
- `rx_done` asserts the cycle after the last ack.
- `s_ready` is a decode of the registered state and has no combinational path from inputs.
- Bits presented while `s_ready`=0 are ignored.

## Structure
- Package `serial_bus_pkg` holds:
  - the state enum `slave_in_state_t`;
  - instruction codes: `S_READ`=1, `S_WRITE`=2, `S_B_READ`=3, `S_B_WRITE`=4.
- Sub-module `serial_deser #(WIDTH)`:
  - Ports: shift enable, bit in, clear, parallel out, last-bit flag.
  - Instantiated twice: address and data.

## Test plan
- Single write: address 0x0A5, `write_en`, `burst_size`=1, data 0x3C LSB-first → exactly one `wr_valid` with `wr_addr`=0x0A5 and `wr_data`=0x3C, then a single `rx_done` pulse.
- Burst write: `burst_size`=3 at address 0xFFF, data 0x11, 0x22, 0x33, `wr_ack` delayed 2 cycles each → writes at 0xFFF, 0x000 and 0x001, with `s_ready` low during each commit.
- Burst read: `burst_size`=4 at address 0x010, `rd_ack` tied high → `rd_addr` sequence 0x010–0x013 on 4 consecutive cycles, then `rx_done`.
- Abort: `sel` drops after 5 of 8 data bits → `rx_abort` pulse, no `wr_valid`, state back in `IDLE`, next transaction correct.
- Reset mid-`WCOMMIT`: `rst` high one cycle while `wr_valid`=1 → all outputs at reset values next cycle; `burst_size`=0 behaves as 1; both `read_en` and `write_en` high → `rx_abort`, no core request.
